// File: rtl/jtag_master_if.sv
// Command/response port of the JTAG master: one command in, one captured-tdo word out.
interface jtag_master_if #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) ();
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [LEN_W-1:0]   cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               busy;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/jtag_master.sv
// JTAG initiator: divides clk down to tck, walks the target TAP for RESET/IR/DR/IDLE
// commands and returns the tdo bits captured during the shift phase.
module jtag_master #(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rstb,
    jtag_master_if.slave  bus,
    output logic          tck,
    output logic          trstb,
    output logic          tms,
    output logic          tdi,
    input  logic          tdo
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {OP_RESET, OP_IR, OP_DR, OP_IDLE} op_e;
    typedef enum logic [2:0] {ST_IDLE, ST_TRST, ST_TMS_WALK, ST_SHIFT, ST_EXIT, ST_RUN} state_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               trstb_q, trstb_d;
    logic               ready_q, ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] cap_q, cap_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         walk_q, walk_d;
    logic [2:0]         walk_n_q, walk_n_d;

    logic               tick, rise, fall, done;
    logic [LEN_W-1:0]   len_eff;
    op_e                cmd_op;

    assign cmd_op  = op_e'(bus.cmd_op);
    assign len_eff = (bus.cmd_len > MAX_L) ? MAX_L : bus.cmd_len;
    assign tick    = (state_q != ST_IDLE) && (div_q == DIV_MAX);
    assign rise    = tick && !tck_q;
    assign fall    = tick && tck_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        div_d       = div_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        trstb_d     = trstb_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        len_d       = len_q;
        data_d      = data_q;
        cap_d       = cap_q;
        cnt_d       = cnt_q;
        walk_d      = walk_q;
        walk_n_d    = walk_n_q;
        done        = 1'b0;

        if (state_q != ST_IDLE) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end
        if (rise) begin
            tck_d = 1'b1;
            // Captured bits enter at the MSB; the final right-shift aligns bit i to shift cycle i.
            if (state_q == ST_SHIFT) begin
                cap_d = {tdo, cap_q[MAX_LEN-1:1]};
            end
        end
        if (fall) begin
            tck_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    ready_d = 1'b0;
                    div_d   = '0;
                    tck_d   = 1'b0;
                    tdi_d   = 1'b0;
                    cap_d   = '0;
                    data_d  = bus.cmd_data;
                    len_d   = len_eff;
                    op_d    = cmd_op;
                    case (cmd_op)
                        OP_RESET: begin
                            state_d = ST_TRST;
                            tms_d   = 1'b1;
                            trstb_d = 1'b0;
                            len_d   = '0;
                        end
                        OP_IR, OP_DR: begin
                            if (len_eff == '0) begin
                                state_d = ST_RUN;
                                cnt_d   = '0;
                                tms_d   = 1'b0;
                            end else begin
                                state_d  = ST_TMS_WALK;
                                tms_d    = 1'b1;
                                walk_d   = (cmd_op == OP_IR) ? 4'b0001 : 4'b0000;
                                walk_n_d = (cmd_op == OP_IR) ? 3'd3 : 3'd2;
                            end
                        end
                        default: begin
                            state_d = ST_RUN;
                            cnt_d   = len_eff;
                            tms_d   = 1'b0;
                        end
                    endcase
                end
            end
            ST_TRST: begin
                if (fall) begin
                    trstb_d  = 1'b1;
                    state_d  = ST_TMS_WALK;
                    tms_d    = 1'b1;
                    walk_d   = 4'b1111;
                    walk_n_d = 3'd4;
                end
            end
            ST_TMS_WALK: begin
                if (fall) begin
                    if (walk_n_q != 3'd0) begin
                        tms_d    = walk_q[0];
                        walk_d   = walk_q >> 1;
                        walk_n_d = walk_n_q - 3'd1;
                    end else if (op_q == OP_RESET) begin
                        state_d = ST_RUN;
                        cnt_d   = LEN_W'(1);
                        tms_d   = 1'b0;
                    end else begin
                        state_d = ST_SHIFT;
                        cnt_d   = len_q;
                        tms_d   = (len_q == LEN_W'(1));
                        tdi_d   = data_q[0];
                    end
                end
            end
            ST_SHIFT: begin
                if (fall) begin
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_EXIT;
                        tms_d   = 1'b1;
                        tdi_d   = 1'b0;
                    end else begin
                        cnt_d  = cnt_q - LEN_W'(1);
                        data_d = data_q >> 1;
                        tdi_d  = data_q[1];
                        tms_d  = (cnt_q == LEN_W'(2));
                    end
                end
            end
            ST_EXIT: begin
                if (fall) begin
                    state_d = ST_RUN;
                    cnt_d   = LEN_W'(1);
                    tms_d   = 1'b0;
                end
            end
            ST_RUN: begin
                // A zero count means a zero-length command: finish without any tck activity.
                if (cnt_q == '0) begin
                    done = 1'b1;
                end else if (fall) begin
                    if (cnt_q == LEN_W'(1)) begin
                        done = 1'b1;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (done) begin
            state_d     = ST_IDLE;
            ready_d     = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_data_d  = cap_q >> (MAX_L - len_q);
            tck_d       = 1'b0;
            tms_d       = 1'b0;
            tdi_d       = 1'b0;
            div_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_RESET;
            div_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            trstb_q     <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            len_q       <= '0;
            data_q      <= '0;
            cap_q       <= '0;
            cnt_q       <= '0;
            walk_q      <= '0;
            walk_n_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            div_q       <= div_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            trstb_q     <= trstb_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            len_q       <= len_d;
            data_q      <= data_d;
            cap_q       <= cap_d;
            cnt_q       <= cnt_d;
            walk_q      <= walk_d;
            walk_n_q    <= walk_n_d;
        end
    end

    assign tck           = tck_q;
    assign tms           = tms_q;
    assign tdi           = tdi_q;
    assign trstb         = trstb_q;
    assign bus.cmd_ready = ready_q;
    assign bus.busy      = !ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_jtag_master.sv
// Scoreboard bench for jtag_master: per-TCK tms/tdi/trstb sequences, captured data and latency.
module tb_jtag_master;
    localparam int CLK_DIV = 2;
    localparam int MAX_LEN = 32;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic clk = 1'b0;
    logic rstb = 1'b0;
    logic tck, trstb, tms, tdi;
    logic tdo = 1'b0;

    jtag_master_if #(.MAX_LEN(MAX_LEN)) bus ();

    jtag_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .rstb  (rstb),
        .bus   (bus),
        .tck   (tck),
        .trstb (trstb),
        .tms   (tms),
        .tdi   (tdi),
        .tdo   (tdo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 k;
        int                 lat;
        logic [63:0]        tms;
        logic [63:0]        tdi;
        logic [63:0]        trst;
        logic [MAX_LEN-1:0] rsp;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] tdo_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          released = 1'b0;

    int          rises = 0, tk = 0, acc_cyc = 0, rsp_cyc = 0, gap = 0;
    logic [63:0] o_tms = '0, o_tdi = '0, o_trst = '0, cur_vec = '0;
    bit          tck_p = 1'b0, rdy_p = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // Reference: the TCK-by-TCK pin sequence each command should produce, from the command rules.
    function automatic exp_t model(input logic [1:0] op, input int len, input logic [MAX_LEN-1:0] data,
                                   input logic [63:0] vec, input bit rel);
        exp_t e;
        bit   tl[$];
        bit   dl[$];
        int   l = (len > MAX_LEN) ? MAX_LEN : len;
        int   pre;
        e.rsp = '0;
        e.tms = '0;
        e.tdi = '0;
        e.trst = '0;
        case (op)
            2'd0: begin
                for (int i = 0; i < 6; i++) begin tl.push_back(1'b1); dl.push_back(1'b0); end
                tl.push_back(1'b0); dl.push_back(1'b0);
            end
            2'd1, 2'd2: begin
                if (l > 0) begin
                    pre = (op == 2'd1) ? 4 : 3;
                    for (int i = 0; i < pre; i++) begin
                        tl.push_back(i < pre - 2);
                        dl.push_back(1'b0);
                    end
                    for (int i = 0; i < l; i++) begin
                        tl.push_back(i == l - 1);
                        dl.push_back(data[i]);
                        e.rsp[i] = vec[pre + i];
                    end
                    tl.push_back(1'b1); dl.push_back(1'b0);
                    tl.push_back(1'b0); dl.push_back(1'b0);
                end
            end
            default: begin
                for (int i = 0; i < l; i++) begin tl.push_back(1'b0); dl.push_back(1'b0); end
            end
        endcase
        e.k = tl.size();
        for (int i = 0; i < e.k; i++) begin
            e.tms[i]  = tl[i];
            e.tdi[i]  = dl[i];
            e.trst[i] = (op == 2'd0) ? (i != 0) : rel;
        end
        e.lat = (e.k == 0) ? 1 : 2 * CLK_DIV * e.k;
        return e;
    endfunction

    // Monitor: plays the target's tdo, records pins at each tck rise, scores each response.
    always @(negedge clk) begin
        if (!rstb) begin
            tck_p = 1'b0;
            rdy_p = 1'b1;
        end else begin
            if (rdy_p && !bus.cmd_ready) begin
                acc_cyc = cyc;
                gap     = acc_cyc - rsp_cyc;
                rises   = 0;
                o_tms   = '0;
                o_tdi   = '0;
                o_trst  = '0;
                cur_vec = (tdo_q.size() > 0) ? tdo_q.pop_front() : 64'd0;
                tk      = 0;
                tdo     = cur_vec[0];
            end
            if (!tck_p && tck) begin
                if (rises < 64) begin
                    o_tms[rises]  = tms;
                    o_tdi[rises]  = tdi;
                    o_trst[rises] = trstb;
                end
                rises++;
            end
            if (tck_p && !tck) begin
                tk++;
                if (tk < 64) tdo = cur_vec[tk];
            end
            if (bus.rsp_valid) begin
                rsp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 want 0 (t=%0t)", $time);
                end else begin
                    exp_t        e;
                    logic [63:0] m;
                    e = exp_q.pop_front();
                    m = (e.k >= 64) ? '1 : ((64'd1 << e.k) - 64'd1);
                    check("tck_count", rises, e.k);
                    check("tms_seq", o_tms & m, e.tms);
                    check("tdi_seq", o_tdi & m, e.tdi);
                    check("trstb_seq", o_trst & m, e.trst);
                    check("rsp_data", bus.rsp_data, e.rsp);
                    check("latency", cyc - acc_cyc, e.lat);
                    check("busy_at_rsp", bus.busy, 0);
                    check("tck_parked", tck, 0);
                end
            end
            tck_p = tck;
            rdy_p = bus.cmd_ready;
        end
    end

    task automatic issue(input logic [1:0] op, input int len, input logic [MAX_LEN-1:0] data,
                         input logic [63:0] vec);
        int n = 0;
        exp_q.push_back(model(op, len, data, vec, released));
        tdo_q.push_back(vec);
        if (op == 2'd0) released = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = LEN_W'(len);
        bus.cmd_data  = data;
        while (!bus.cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("accept_timeout", 1, 0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_len   = LEN_W'($urandom);
        bus.cmd_data  = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            check("rsp_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [63:0] vec;
        logic [MAX_LEN-1:0] d;
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_len   = '0;
        bus.cmd_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_tck", tck, 0);
        check("rst_tms", tms, 1);
        check("rst_tdi", tdi, 0);
        check("rst_trstb", trstb, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        rstb = 1'b1;
        repeat (2) @(negedge clk);

        // Scan before any RESET: legal, trstb still low throughout.
        issue(2'd2, 3, 32'h5, {$urandom, $urandom});
        wait_idle();
        issue(2'd0, 9, 32'hFFFF_FFFF, 64'd0);
        wait_idle();

        // DR L=8 against a 1-bit bypass register that captures 0.
        d   = 32'hA5;
        vec = '0;
        for (int i = 1; i < 8; i++) vec[3 + i] = d[i - 1];
        issue(2'd2, 8, d, vec);
        wait_idle();

        issue(2'd1, 4, 32'hE, {$urandom, $urandom});
        wait_idle();

        // cmd_valid held across a busy scan, then a zero-length scan.
        issue(2'd2, 6, $urandom, {$urandom, $urandom});
        issue(2'd2, 0, $urandom, {$urandom, $urandom});
        wait_idle();
        check("b2b_accept_gap", gap, 1);

        issue(2'd2, 40, $urandom, {$urandom, $urandom});
        wait_idle();
        issue(2'd1, 33, $urandom, {$urandom, $urandom});
        wait_idle();
        issue(2'd3, 5, $urandom, {$urandom, $urandom});
        wait_idle();
        issue(2'd3, 0, $urandom, {$urandom, $urandom});
        wait_idle();
        issue(2'd1, 1, $urandom, {$urandom, $urandom});
        wait_idle();

        for (int r = 0; r < 30; r++) begin
            issue(2'($urandom_range(0, 3)), $urandom_range(0, 40), $urandom, {$urandom, $urandom});
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();

        // Abort in the 5th shift cycle of a DR scan.
        issue(2'd2, 16, $urandom, {$urandom, $urandom});
        n = 0;
        while (rises < 8 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("abort_wait_timeout", 1, 0);
        rstb = 1'b0;
        #1;
        check("abort_tck", tck, 0);
        check("abort_tms", tms, 1);
        check("abort_tdi", tdi, 0);
        check("abort_trstb", trstb, 0);
        check("abort_cmd_ready", bus.cmd_ready, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_rsp_valid", bus.rsp_valid, 0);
        exp_q.delete();
        tdo_q.delete();
        released = 1'b0;
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        repeat (80) @(negedge clk);

        issue(2'd0, 0, '0, 64'd0);
        issue(2'd2, 12, $urandom, {$urandom, $urandom});
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
